// File: rtl/ebr_write_packer.sv
// ebr_write_packer: burst write front end for one iCE40UP 4 kbit EBR; places narrow words on the 16-bit bus per width mode
// Ports: clk, resetn (sync, active-low); cmd_valid/cmd_ready/cmd_addr/cmd_len burst command;
//   s_valid/s_ready/s_data/s_bmask data stream; ram_waddr/ram_wdata/ram_wmask/ram_we/ram_wclke EBR write port;
//   busy, done (completion pulse), err (rejected command or end-of-array stop pulse).
// Build option: EBR_WR_WRAP_EN wraps the address at DEPTH-1 instead of stopping the burst.
module ebr_write_packer #(
  parameter int WRITE_MODE = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [10:0] cmd_addr,
  input  logic [10:0] cmd_len,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  input  logic [1:0]  s_bmask,
  output logic [10:0] ram_waddr,
  output logic [15:0] ram_wdata,
  output logic [15:0] ram_wmask,
  output logic        ram_we,
  output logic        ram_wclke,
  output logic        busy,
  output logic        done,
  output logic        err
);
  localparam int STRIDE = 1 << WRITE_MODE;
  localparam int OFF = WRITE_MODE == 2 ? 1 : WRITE_MODE == 3 ? 3 : 0;
  localparam int DEPTH = 256 << WRITE_MODE;
  localparam logic [10:0] AMAX = 11'(DEPTH - 1);
  if (WRITE_MODE < 0 || WRITE_MODE > 3) begin : g_bad_mode
    $fatal(1, "ebr_write_packer: WRITE_MODE must be 0..3");
  end
  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;
  state_t state, state_nx;
  logic [10:0] addr, remaining;
  logic [15:0] place, mask;
  logic cmd_acc, beat, bad_addr, last, stop;
  // Each used data bit lands every STRIDE bits starting at OFF, where the decoder samples it.
  for (genvar j = 0; j < 16; j++) begin : g_place
    if (j % STRIDE == OFF) begin : g_bit
      assign place[j] = s_data[j / STRIDE];
    end else begin : g_zero
      assign place[j] = 1'b0;
    end
  end
  assign mask = WRITE_MODE == 0 ? {{8{s_bmask[1]}}, {8{s_bmask[0]}}} : 16'h0000;
  // Gated by resetn so every output reads 0 while reset is held.
  assign cmd_ready = resetn && state == IDLE;
  assign s_ready = state == BURST;
  assign cmd_acc = cmd_valid && cmd_ready;
  assign beat = s_valid && s_ready;
  assign bad_addr = {1'b0, cmd_addr} >= 12'(DEPTH);
  assign last = remaining == 11'd0;
`ifdef EBR_WR_WRAP_EN
  assign stop = 1'b0;
`else
  // Writing the top word with beats still owed ends the burst early.
  assign stop = addr == AMAX && !last;
`endif
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign ram_wclke = ram_we;
  always_comb begin
    state_nx = IDLE;
    state_nx = state == IDLE  ? (cmd_acc && !bad_addr ? BURST : IDLE)
             : state == BURST ? (beat && (last || stop) ? DONE : BURST)
             : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      addr      <= '0;
      remaining <= '0;
      ram_we    <= 1'b0;
      ram_waddr <= '0;
      ram_wdata <= '0;
      ram_wmask <= '0;
      err       <= 1'b0;
    end else begin
      addr      <= cmd_acc ? cmd_addr : beat ? (addr + 11'd1) & AMAX : addr;
      remaining <= cmd_acc ? cmd_len : beat ? remaining - 11'd1 : remaining;
      ram_we    <= beat;
      ram_waddr <= beat ? addr : '0;
      ram_wdata <= beat ? place : '0;
      ram_wmask <= beat ? mask : '0;
      err       <= (cmd_acc && bad_addr) || (beat && stop);
    end
  end
endmodule
